// File: rtl/dpwm_pkg.sv
// Shared state encoding, default widths and phase-offset helper for the multiphase DPWM.
package dpwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } dpwm_state_e;

  localparam int CNT_W_DEF    = 10;
  localparam int DUTY_MAX_DEF = 972;

  // Counts between consecutive phase turn-on points within one period.
  function automatic int ph_off(input int cnt_w, input int n_phase);
    return (1 << cnt_w) / n_phase;
  endfunction

endpackage

// File: rtl/dpwm_phase_cmp.sv
// One phase slice: shifts the shared period count by a fixed offset and
// registers the duty comparison that drives that phase's gate enable.
module dpwm_phase_cmp
  import dpwm_pkg::*;
#(
  parameter int               CNT_W  = CNT_W_DEF,
  parameter logic [CNT_W-1:0] OFFSET = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [CNT_W-1:0] duty_i,
  input  logic             active_i,
  output logic             pwm_o
);

  logic [CNT_W-1:0] lc;
  logic             pwm_q;

  // Natural CNT_W-bit wrap gives the modulo local count.
  assign lc = cnt_i - OFFSET;

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= active_i && (lc < duty_i);
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/multiphase_dpwm.sv
// Counter-based interleaved DPWM with period-boundary duty double-buffering.
// Optional soft-start ramp ceiling is enabled by defining DPWM_SOFTSTART_EN.
module multiphase_dpwm
  import dpwm_pkg::*;
#(
  parameter int N_PHASE  = 4,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DUTY_MAX = DUTY_MAX_DEF
`ifdef DPWM_SOFTSTART_EN
  ,
  parameter int SS_STEP  = 8
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [CNT_W-1:0]   d_comp,
  input  logic               d_valid,
  output logic [N_PHASE-1:0] pwm_out,
  output logic               period_sync,
  output logic [CNT_W-1:0]   duty_act,
  output logic               busy
);

  localparam logic [CNT_W-1:0] DUTY_MAX_C = CNT_W'(DUTY_MAX);

  dpwm_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] duty_pend_q;
  logic [CNT_W-1:0] duty_act_q;
  logic [CNT_W-1:0] duty_eff;
  logic             period_sync_q;
  logic             boundary;
  logic             active;

  assign boundary = (cnt_q == '1);

  // Re-enable during STOP resumes immediately; the counter never stopped, so alignment holds.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = STOP;
      STOP:    if (enable) state_d = RUN;
               else if (boundary) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Compare is suppressed on the edge that enters IDLE so outputs drop at the wrap.
  assign active = (state_q != IDLE) && (state_d != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      duty_pend_q   <= '0;
      duty_act_q    <= '0;
      period_sync_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      period_sync_q <= active && (cnt_q == '0);
      if (d_valid) begin
        duty_pend_q <= (d_comp > DUTY_MAX_C) ? DUTY_MAX_C : d_comp;
      end
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (enable) duty_act_q <= duty_pend_q;
        end
        RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (boundary) duty_act_q <= duty_pend_q;
        end
        default: cnt_q <= cnt_q + 1'b1;
      endcase
    end
  end

`ifdef DPWM_SOFTSTART_EN
  localparam logic [CNT_W-1:0] SS_STEP_C = CNT_W'(SS_STEP);

  logic [CNT_W-1:0] ss_lim_q;

  // Ceiling restarts from zero on every cold start and climbs once per period.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_lim_q <= '0;
    end else if (state_q == IDLE) begin
      if (enable) ss_lim_q <= '0;
    end else if (boundary) begin
      if (ss_lim_q >= DUTY_MAX_C - SS_STEP_C) ss_lim_q <= DUTY_MAX_C;
      else                                    ss_lim_q <= ss_lim_q + SS_STEP_C;
    end
  end

  assign duty_eff = (duty_act_q < ss_lim_q) ? duty_act_q : ss_lim_q;
`else
  assign duty_eff = duty_act_q;
`endif

  for (genvar k = 0; k < N_PHASE; k++) begin : g_phase
    dpwm_phase_cmp #(
      .CNT_W  (CNT_W),
      .OFFSET (CNT_W'(k * ph_off(CNT_W, N_PHASE)))
    ) u_cmp (
      .clk      (clk),
      .rst      (rst),
      .cnt_i    (cnt_q),
      .duty_i   (duty_eff),
      .active_i (active),
      .pwm_o    (pwm_out[k])
    );
  end

  assign period_sync = period_sync_q;
  assign duty_act    = duty_eff;
  assign busy        = (state_q != IDLE);

endmodule
